vote_logger: RTL
================

// Module: vote_logger
// PURPOSE
//  Upstream voting-mode stage of the EVM. Turns debounced candidate button presses into counted
//  votes, one per press, with a lockout window after each accepted vote.
//  Produces the six per-candidate tallies and the valid_vote_casted pulse.
//  The downstream result/mode selector consumes both.
// PARAMETERS
//  LOCKOUT_CYCLES  100000000  cycles after an accepted vote during which all presses are ignored (>=1)
//  VOTE_W          8          width of each candidate tally (saturating)
// PORTS
//  clock                      in   1       single system clock, all logic on rising edge
//  reset                      in   1       asynchronous, active-high; clears all state
//  mode                       in   1       0 = voting, 1 = result display (voting disabled)
//  candidateN_button_pressed  in   1       N=1..6; debounced, synchronous to clock, level
//  candidateN_vote            out  VOTE_W  N=1..6; registered tally for candidate N
//  valid_vote_casted          out  1       1-cycle pulse on each accepted vote
//  invalid_press              out  1       1-cycle pulse when a press is rejected (multi-button)
//  total_votes                out  11      registered sum of accepted votes, saturating at 2047
//  busy                       out  1       high while state != IDLE
// BEHAVIOUR
//  Reset
//   - All tallies, total_votes and pulses are 0.
//   - State = WAIT_RELEASE and the lockout counter = 0.
//   - Button history register = 6'b111111, so a button held through reset never counts.
//  Edge detection
//   - rise[i] = btn[i] & ~btn_q[i]; btn_q is updated every cycle in every state.
//  States
//   - IDLE:
//     - If mode==0 and exactly one bit of rise is set and no other button is high:
//       tally[i]++ and total++ (both saturating), valid_vote_casted=1 next cycle, go to LOCKOUT.
//     - If mode==0 and rise!=0 but more than one button is high: invalid_press=1, no count,
//       go to WAIT_RELEASE.
//   - LOCKOUT:
//     - Counter increments each cycle. At LOCKOUT_CYCLES-1, clear the counter and go to
//       WAIT_RELEASE.
//     - Presses are ignored, with no invalid_press.
//   - WAIT_RELEASE: when all six buttons are low, go to IDLE.
//  Latency
//   - Button first sampled high at edge k (low at k-1): tally and pulse are visible after edge k.
//   - valid_vote_casted is high for exactly one cycle.
//  Mode
//   - mode==1 in any state: no counting, tallies hold.
//   - From LOCKOUT, the counter clears and the state goes to WAIT_RELEASE.
//  Saturation
//   - A tally at 255 stays 255, but valid_vote_casted still pulses.
//   - total_votes saturates independently.
//  Simultaneous rises
//   - Simultaneous rises on two or more buttons are one rejected press (one invalid_press pulse).
//  Reset mid-operation
//   - Asynchronous reset mid-LOCKOUT aborts immediately; no pulse is generated.
// STRUCTURE
//  - evm_pkg (shared): NUM_CANDIDATES=6, VOTE_W=8, TOTAL_W=11, state encodings
//    IDLE/LOCKOUT/WAIT_RELEASE.
//  - Sub-module vote_press_detect: btn_q history register, rise vector, one-hot check
//    (valid_single, multi) and the all_released flag.
//  - Top level: FSM, lockout counter, and the tally/total saturating adders.
// TESTING  (bench uses LOCKOUT_CYCLES=4)
//  - Single vote: reset, then mode=0, press cand2 for 10 cycles ->
//    candidate2_vote=1, total=1, one valid pulse.
//  - Lockout: press cand1, release, press cand1 again 2 cycles later ->
//    second press ignored, candidate1_vote=1.
//    Re-press after release past lockout -> candidate1_vote=2.
//  - Multi-press: cand3 and cand5 rise in the same cycle -> invalid_press pulse, both tallies 0.
//    After release, cand5 press -> candidate5_vote=1.
//  - Saturation: 260 valid cand6 votes -> candidate6_vote=255, total_votes=260, 260 valid pulses.
//  - Mode gating: mode=1, press cand4 -> no pulse, tally 0. mode back to 0 while cand4 still held
//    -> no vote until release and re-press.
//  - Reset: assert reset during LOCKOUT with cand1 held -> all outputs 0.
//    Release reset with cand1 held -> no vote; release then press -> candidate1_vote=1.

Source files
------------

// File: rtl/evm_pkg.sv
// -----------------------------------------------------------------------------
// evm_pkg
// Shared constants and types for the EVM voting path.
//   NUM_CANDIDATES : number of candidate buttons / tallies
//   VOTE_W         : default width of each per-candidate tally
//   TOTAL_W        : width of the accepted-vote total
//   vote_state_t   : voting FSM states (IDLE / LOCKOUT / WAIT_RELEASE)
//   is_onehot()    : true when exactly one bit of a button vector is set
// -----------------------------------------------------------------------------
package evm_pkg;

    localparam int NUM_CANDIDATES = 6;
    localparam int VOTE_W         = 8;
    localparam int TOTAL_W        = 11;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        LOCKOUT      = 2'd1,
        WAIT_RELEASE = 2'd2
    } vote_state_t;

    // v & (v-1) clears the lowest set bit; a non-zero result means two or more bits.
    function automatic logic is_onehot(input logic [NUM_CANDIDATES-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/vote_press_detect.sv
// -----------------------------------------------------------------------------
// vote_press_detect
// Button history register and press classification for the voting FSM.
// Ports:
//   clock          in   system clock, rising edge
//   reset          in   asynchronous, active-high
//   i_btn          in   6  debounced candidate buttons (bit 0 = candidate 1)
//   o_rise         out  6  per-button rising edge this cycle
//   o_valid_single out  1  a button rose and it is the only button high
//   o_multi        out  1  a button rose while two or more buttons are high
//   o_all_released out  1  all buttons are low
// -----------------------------------------------------------------------------
module vote_press_detect
    import evm_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_CANDIDATES-1:0] i_btn,
    output logic [NUM_CANDIDATES-1:0] o_rise,
    output logic                      o_valid_single,
    output logic                      o_multi,
    output logic                      o_all_released
);

    logic [NUM_CANDIDATES-1:0] r_btn_q;
    logic                      w_any_rise;
    logic                      w_btn_onehot;

    // History resets to all-ones so a button held through reset never
    // produces a rising edge when reset is released.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_btn_q <= '1;
        end else begin
            r_btn_q <= i_btn;
        end
    end

    assign o_rise         = i_btn & ~r_btn_q;
    assign w_any_rise     = |o_rise;
    assign w_btn_onehot   = is_onehot(i_btn);
    // A rise implies at least one button is high, so "not one-hot" here
    // always means several buttons are held together.
    assign o_valid_single = w_any_rise & w_btn_onehot;
    assign o_multi        = w_any_rise & ~w_btn_onehot;
    assign o_all_released = (i_btn == '0);

endmodule

// File: rtl/vote_logger.sv
// -----------------------------------------------------------------------------
// vote_logger
// Voting-mode stage of the EVM: turns candidate button presses into counted
// votes (one per press) with a lockout window after each accepted vote.
// Parameters:
//   LOCKOUT_CYCLES  cycles after an accepted vote during which presses are ignored (>=1)
//   VOTE_W          width of each saturating candidate tally
// Ports:
//   clock                          in   system clock, rising edge
//   reset                          in   asynchronous, active-high
//   mode                           in   0 = voting, 1 = result display
//   candidate1..6_button_pressed   in   debounced buttons, level
//   candidate1..6_vote             out  VOTE_W registered tallies
//   valid_vote_casted              out  1-cycle pulse per accepted vote
//   invalid_press                  out  1-cycle pulse per rejected multi-button press
//   total_votes                    out  11 saturating sum of accepted votes
//   busy                           out  high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module vote_logger #(
    parameter int LOCKOUT_CYCLES = 100000000,
    parameter int VOTE_W         = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mode,
    input  logic              candidate1_button_pressed,
    input  logic              candidate2_button_pressed,
    input  logic              candidate3_button_pressed,
    input  logic              candidate4_button_pressed,
    input  logic              candidate5_button_pressed,
    input  logic              candidate6_button_pressed,
    output logic [VOTE_W-1:0] candidate1_vote,
    output logic [VOTE_W-1:0] candidate2_vote,
    output logic [VOTE_W-1:0] candidate3_vote,
    output logic [VOTE_W-1:0] candidate4_vote,
    output logic [VOTE_W-1:0] candidate5_vote,
    output logic [VOTE_W-1:0] candidate6_vote,
    output logic              valid_vote_casted,
    output logic              invalid_press,
    output logic [10:0]       total_votes,
    output logic              busy
);

    import evm_pkg::*;

    localparam int CNT_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCKOUT_CYCLES - 1);

    logic [NUM_CANDIDATES-1:0] w_btn;
    logic [NUM_CANDIDATES-1:0] w_rise;
    logic                      w_valid_single;
    logic                      w_multi;
    logic                      w_all_released;

    vote_state_t      r_state;
    vote_state_t      w_state_next;
    logic [CNT_W-1:0] r_lock_cnt;
    logic [CNT_W-1:0] w_lock_cnt_next;
    logic             w_accept;
    logic             w_reject;

    logic               r_valid;
    logic               r_invalid;
    logic [TOTAL_W-1:0] r_total;

    assign w_btn = {candidate6_button_pressed, candidate5_button_pressed,
                    candidate4_button_pressed, candidate3_button_pressed,
                    candidate2_button_pressed, candidate1_button_pressed};

    vote_press_detect u_detect (
        .clock          (clock),
        .reset          (reset),
        .i_btn          (w_btn),
        .o_rise         (w_rise),
        .o_valid_single (w_valid_single),
        .o_multi        (w_multi),
        .o_all_released (w_all_released)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= WAIT_RELEASE;
            r_lock_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_lock_cnt <= w_lock_cnt_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_lock_cnt_next = r_lock_cnt;
        w_accept        = 1'b0;
        w_reject        = 1'b0;
        case (r_state)
            IDLE: begin
                if (!mode) begin
                    if (w_valid_single) begin
                        w_accept     = 1'b1;
                        w_state_next = LOCKOUT;
                    end else if (w_multi) begin
                        w_reject     = 1'b1;
                        w_state_next = WAIT_RELEASE;
                    end
                end
            end
            LOCKOUT: begin
                // Switching to result mode abandons the lockout early; either
                // way the buttons must all be released before the next vote.
                if (mode || (r_lock_cnt == CNT_LAST)) begin
                    w_lock_cnt_next = '0;
                    w_state_next    = WAIT_RELEASE;
                end else begin
                    w_lock_cnt_next = r_lock_cnt + 1'b1;
                end
            end
            WAIT_RELEASE: begin
                if (w_all_released) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_lock_cnt_next = '0;
                w_state_next    = WAIT_RELEASE;
            end
        endcase
    end

    // --------------------------------------------------- tallies and total
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CANDIDATES; gi++) begin : gen_tally
            logic [VOTE_W-1:0] r_tally;
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_tally <= '0;
                end else if (w_accept && w_rise[gi] && (r_tally != '1)) begin
                    r_tally <= r_tally + 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_total   <= '0;
            r_valid   <= 1'b0;
            r_invalid <= 1'b0;
        end else begin
            r_valid   <= w_accept;
            r_invalid <= w_reject;
            if (w_accept && (r_total != '1)) begin
                r_total <= r_total + 1'b1;
            end
        end
    end

    assign candidate1_vote   = gen_tally[0].r_tally;
    assign candidate2_vote   = gen_tally[1].r_tally;
    assign candidate3_vote   = gen_tally[2].r_tally;
    assign candidate4_vote   = gen_tally[3].r_tally;
    assign candidate5_vote   = gen_tally[4].r_tally;
    assign candidate6_vote   = gen_tally[5].r_tally;
    assign valid_vote_casted = r_valid;
    assign invalid_press     = r_invalid;
    assign total_votes       = r_total;
    assign busy              = (r_state != IDLE);

endmodule
